neuron_mac: RTL



---
 rtl/neuron_mac_if.sv | 22 ++
 rtl/neuron_mac.sv | 128 ++++++++++++
 2 files changed

// File: rtl/neuron_mac_if.sv
// Stream bundle for neuron_mac: (x, w, bias) beat input and saturated 8-bit result output.
interface neuron_mac_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] x;
   logic [7:0] w;
   logic [7:0] bias;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sat;

   modport master (
      output in_valid, x, w, bias, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, x, w, bias, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate of N_INPUTS (x, w) beats, plus bias, saturated to 8 bits.
//
// state  | meaning
// IDLE   | waiting for the first beat; first beat loads acc and samples bias
// ACC    | accumulating the remaining beats
// BIAS   | one cycle: add bias, saturate, register the result
// OUT    | result held on the output until out_ready
module neuron_mac #(
   parameter int N_INPUTS = 4,
   parameter int ACC_W    = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   neuron_mac_if.slave  bus,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_BIAS,
      S_OUT
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(N_INPUTS - 1);

   state_t             state;
   state_t             state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   total;
   logic [15:0]        prod;
   logic [7:0]         bias_q;
   logic [7:0]         cnt;
   logic               in_rdy;
   logic               beat;
   logic               out_valid_q;
   logic [7:0]         out_data_q;
   logic               out_sat_q;

   // in_ready depends on state and reset only, never on in_valid
   assign in_rdy = rst_n && ((state == S_IDLE) || (state == S_ACC));
   assign beat   = bus.in_valid && in_rdy;
   assign prod   = {8'd0, bus.x} * {8'd0, bus.w};
   assign total  = acc + ACC_W'(bias_q);

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign busy          = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (beat) begin
               state_nxt = (N_INPUTS == 1) ? S_BIAS : S_ACC;
            end
         end
         S_ACC: begin
            if (beat && (cnt == LAST_CNT)) begin
               state_nxt = S_BIAS;
            end
         end
         S_BIAS: begin
            state_nxt = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         cnt         <= '0;
         bias_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (beat) begin
                  acc    <= ACC_W'(prod);
                  bias_q <= bus.bias;
                  cnt    <= 8'd1;
               end
            end
            S_ACC: begin
               if (beat) begin
                  acc <= acc + ACC_W'(prod);
                  cnt <= cnt + 8'd1;
               end
            end
            S_BIAS: begin
               out_data_q  <= (total > ACC_W'(255)) ? 8'hFF : total[7:0];
               out_sat_q   <= (total > ACC_W'(255));
               out_valid_q <= 1'b1;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  acc         <= '0;
                  cnt         <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
